mem_access_ctrl: RTL and testbench

- MEM-stage data-memory initiator for the rv32i pipeline; the write/issue side of the load-extraction path in writeback.
- Turns a load/store micro-op into a single data-memory request with a word-aligned address, byte enables and lane-replicated store data.
- Waits for the memory response, stalls the pipeline while the request is outstanding, and registers the raw read word for writeback.
- Writeback performs byte/half extraction and sign/zero extension.

---
 rtl/mem_access_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage data-memory initiator. It turns a load/store micro-op into one word-aligned request with byte enables and lane-replicated store data.
// Latency: the request appears 1 cycle after start. done or misaligned pulses 1 cycle after dmem_resp or after the rejected start.
// Backpressure: stall is held while the request is outstanding and drops in the dmem_resp cycle. DONE waits for advance before accepting the next op.
//
// Ports:
//   clk, rst                  pipeline clock, asynchronous active-high reset
//   req_valid/is_load/is_store/funct3/addr/store_data   micro-op from MEM stage
//   advance                   MEM->WB pipeline move; the only exit from DONE
//   dmem_resp/dmem_rdata      memory completion and read word
//   dmem_read/dmem_write/dmem_address/dmem_byte_enable/dmem_wdata   registered request
//   stall                     combinational pipeline freeze
//   rdata_out                 raw read word of the last completed load
//   done/misaligned           one-cycle completion / rejection pulses
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  input  logic                  advance,
  input  logic                  dmem_resp,
  input  logic [31:0]           dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [3:0]            dmem_byte_enable,
  output logic [31:0]           dmem_wdata,
  output logic                  stall,
  output logic [31:0]           rdata_out,
  output logic                  done,
  output logic                  misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        start;
  logic        misaligned_comb;
  logic        size_half;
  logic        size_word;
  logic [3:0]  be_comb;
  logic [31:0] wdata_comb;

  // funct3[2] only selects zero- versus sign-extension. Writeback handles that, so it is not needed here.
  logic        unused_funct3;
  assign unused_funct3 = funct3[2];

  always_comb begin
    start           = req_valid & (is_load | is_store) & (state == IDLE);
    size_half       = (funct3[1:0] == 2'b01);
    size_word       = funct3[1];
    misaligned_comb = (size_half & addr[0]) | (size_word & (addr[1:0] != 2'b00));

    // If both opcode flags are set, the op is treated as a store.
    be_comb    = 4'b1111;
    wdata_comb = 32'h0;
    if (is_store) begin
      if (size_word) begin
        be_comb    = 4'b1111;
        wdata_comb = store_data;
      end else if (size_half) begin
        be_comb    = 4'b0011 << {addr[1], 1'b0};
        wdata_comb = {2{store_data[15:0]}};
      end else begin
        be_comb    = 4'b0001 << addr[1:0];
        wdata_comb = {4{store_data[7:0]}};
      end
    end
  end

  // stall drops in the response cycle, so the pipeline moves at that same edge.
  assign stall = ((state == IDLE) & start & ~misaligned_comb) |
                 ((state == BUSY) & ~dmem_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_byte_enable <= 4'b0;
      dmem_wdata       <= 32'h0;
      rdata_out        <= 32'h0;
      done             <= 1'b0;
      misaligned       <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (misaligned_comb) begin
              misaligned <= 1'b1;
              state      <= DONE;
            end else begin
              dmem_address     <= {addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_byte_enable <= be_comb;
              dmem_wdata       <= wdata_comb;
              dmem_write       <= is_store;
              dmem_read        <= ~is_store;
              state            <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            // dmem_read is still set only for a load, so stores leave rdata_out unchanged.
            if (dmem_read) begin
              rdata_out <= dmem_rdata;
            end
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Holding here stops the same instruction from being reissued until the pipeline moves.
          if (advance) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int K_REQ  = 0;
  localparam int K_DONE = 1;
  localparam int K_MIS  = 2;

  typedef struct {
    int          kind;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          req_cyc;
    int          stall_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store, advance, dmem_resp;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, dmem_rdata;
  logic        dmem_read, dmem_write, stall, done, misaligned;
  logic [31:0] dmem_address, dmem_wdata, rdata_out;
  logic [3:0]  dmem_byte_enable;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        stim_done = 1'b0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .advance(advance),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata), .stall(stall), .rdata_out(rdata_out), .done(done),
    .misaligned(misaligned)
  );

  // ---------------- stimulus ----------------
  function automatic exp_t mk(int kind, logic rd, logic wr, logic [31:0] a, logic [3:0] be,
                              logic [31:0] wd, logic [31:0] rdat, int rc, int sc);
    exp_t e;
    e.kind = kind; e.rd = rd; e.wr = wr; e.addr = a; e.be = be; e.wdata = wd;
    e.rdata = rdat; e.req_cyc = rc; e.stall_cyc = sc;
    return e;
  endfunction

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a;
    store_data = sd; advance = 1'b0; dmem_resp = 1'b0;
  endtask

  // Normal access. n = request cycles up to and including the response cycle.
  // hold = extra DONE cycles with advance low and req_valid still high.
  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int n, input int hold,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
    if (!st) exp_rdata = rd;
    exp_q.push_back(mk(K_REQ, !st, st, e_addr, e_be, e_wd, 32'h0, 0, 0));
    exp_q.push_back(mk(K_DONE, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, exp_rdata, n, n));
    drive_op(ld, st, f3, a, sd);
    @(posedge clk); #1;
    for (int i = 1; i < n; i++) begin @(posedge clk); #1; end
    dmem_resp = 1'b1; dmem_rdata = rd; advance = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0; advance = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    advance = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    advance = 1'b0;
  endtask

  task automatic mis_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a);
    exp_q.push_back(mk(K_MIS, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0));
    drive_op(ld, st, f3, a, 32'h5A5A5A5A);
    @(posedge clk); #1;
    advance = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    advance = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0;
    store_data = 0; advance = 0; dmem_resp = 0; dmem_rdata = 0; exp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // sb / sh / sh
    access(0, 1, 3'b000, 32'h00001003, 32'hAABBCCDD, 32'hBAD0BAD0, 2, 0, 32'h00001000, 4'b1000, 32'hDDDDDDDD);
    access(0, 1, 3'b001, 32'h00002002, 32'h12345678, 32'hBAD0BAD0, 1, 0, 32'h00002000, 4'b1100, 32'h56785678);
    access(0, 1, 3'b001, 32'h00002000, 32'h12345678, 32'hBAD0BAD0, 1, 0, 32'h00002000, 4'b0011, 32'h56785678);
    // lw with a 3-cycle response, then 5 cycles parked in DONE
    access(1, 0, 3'b010, 32'h00000040, 32'h0, 32'hCAFEF00D, 3, 5, 32'h00000040, 4'b1111, 32'h0);
    // misaligned lh / sw
    mis_access(1, 0, 3'b001, 32'h00000011);
    mis_access(0, 1, 3'b010, 32'h00000012);
    // lbu, aligned lh, then a store with both flags set (behaves as a store)
    access(1, 0, 3'b100, 32'h00000103, 32'h0, 32'h11223344, 1, 0, 32'h00000100, 4'b1111, 32'h0);
    access(1, 0, 3'b001, 32'h00000012, 32'h0, 32'h5555AAAA, 2, 0, 32'h00000010, 4'b1111, 32'h0);
    access(1, 1, 3'b010, 32'h00000200, 32'hDEADBEEF, 32'hBAD0BAD0, 1, 0, 32'h00000200, 4'b1111, 32'hDEADBEEF);
    // reset during BUSY of a store, followed by a late response
    exp_q.push_back(mk(K_REQ, 1'b0, 1'b1, 32'h00000300, 4'b1111, 32'h01020304, 32'h0, 0, 0));
    drive_op(0, 1, 3'b010, 32'h00000300, 32'h01020304);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; exp_rdata = 32'h0;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    // The controller must be back in IDLE, and rdata_out must still be cleared.
    access(0, 1, 3'b000, 32'h00000401, 32'h00000077, 32'hBAD0BAD0, 1, 0, 32'h00000400, 4'b0010, 32'h77777777);
    repeat (3) begin @(posedge clk); #1; end
    stim_done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    int   cyc = 0;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    logic prev_req = 1'b0;
    logic cur_req;
    exp_t e;
    exp_t held;
    held = mk(K_REQ, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    while (!stim_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_read", {31'h0, dmem_read}, 32'h0);
        chk("rst_write", {31'h0, dmem_write}, 32'h0);
        chk("rst_addr", dmem_address, 32'h0);
        chk("rst_be", {28'h0, dmem_byte_enable}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        req_cnt = 0; stall_cnt = 0; prev_req = 1'b0;
      end else begin
        cur_req = dmem_read | dmem_write;
        if (stall) stall_cnt++;
        if (cur_req) req_cnt++;
        if (cur_req && !prev_req) begin
          if (exp_q.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("req_kind", e.kind, K_REQ);
            chk("req_read", {31'h0, dmem_read}, {31'h0, e.rd});
            chk("req_write", {31'h0, dmem_write}, {31'h0, e.wr});
            chk("req_addr", dmem_address, e.addr);
            chk("req_be", {28'h0, dmem_byte_enable}, {28'h0, e.be});
            chk("req_wdata", dmem_wdata, e.wdata);
            held = e;
          end
        end else if (cur_req) begin
          chk("hold_read", {31'h0, dmem_read}, {31'h0, held.rd});
          chk("hold_addr", dmem_address, held.addr);
          chk("hold_be", {28'h0, dmem_byte_enable}, {28'h0, held.be});
          chk("hold_wdata", dmem_wdata, held.wdata);
        end
        if (done || misaligned) begin
          if (exp_q.size() == 0) chk("unexpected_pulse", 32'h1, 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("pulse_kind", done ? K_DONE : K_MIS, e.kind);
            if (done) chk("done_rdata", rdata_out, e.rdata);
            chk("req_cycles", req_cnt, e.req_cyc);
            chk("stall_cycles", stall_cnt, e.stall_cyc);
          end
          req_cnt = 0; stall_cnt = 0;
        end
        prev_req = cur_req;
      end
    end
    if (cyc >= 5000) chk("timeout", 32'h1, 32'h0);
    chk("pending_expectations", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
